m_axil_wr_queue: RTL

M_AXIL_WR_QUEUE -- requirements
Module: m_axil_wr_queue

---
 rtl/axil_pkg.sv | 15 +
 rtl/sync_fifo.sv | 41 ++++
 rtl/m_axil_wr_queue.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite write queue: FSM states and BRESP codes.
package axil_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } wr_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read; the extra pointer MSB
// tells full apart from empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wptr;
    logic [PW:0]      r_rptr;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign o_dout  = r_mem[r_rptr[PW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_push && !o_full)
            r_mem[r_wptr[PW-1:0]] <= i_din;
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push && !o_full) r_wptr <= r_wptr + 1'b1;
            if (i_pop && !o_empty) r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule

// File: rtl/m_axil_wr_queue.sv
// AXI4-Lite write master fed by a command queue; one transaction in flight,
// independent AW/W handshakes, sticky error and stall flags.
module m_axil_wr_queue
    import axil_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                i_clk,
    input  logic                i_resetn,
    input  logic                i_wr,
    input  logic [ADDR_W-1:0]   i_addrin,
    input  logic [DATA_W-1:0]   i_din,
    input  logic [DATA_W/8-1:0] i_strb,
    output logic                o_full,
    output logic                o_busy,
    output logic                o_done,
    output logic [1:0]          o_resp,
    output logic                o_err,
    output logic                o_ovf,
    output logic                o_stall,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    input  logic [1:0]          m_axi_bresp
);
    localparam int SW    = DATA_W / 8;
    localparam int EW    = ADDR_W + DATA_W + SW;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    wr_state_t         r_state, w_state_nxt;
    logic              r_awvalid, r_wvalid, r_bready;
    logic [ADDR_W-1:0] r_awaddr;
    logic [DATA_W-1:0] r_wdata;
    logic [SW-1:0]     r_wstrb;
    logic              r_done, r_err, r_ovf, r_stall;
    logic [1:0]        r_resp;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_full, w_empty, w_pop;
    logic [EW-1:0]     w_head;
    logic              w_aw_hs, w_w_hs, w_b_hs;
    logic              w_aw_ok, w_w_ok;

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_push   (i_wr),
        .i_din    ({i_addrin, i_din, i_strb}),
        .i_pop    (w_pop),
        .o_dout   (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    assign w_aw_hs = r_awvalid && m_axi_awready;
    assign w_w_hs  = r_wvalid && m_axi_wready;
    assign w_b_hs  = m_axi_bvalid && r_bready;
    // a channel is finished if it handshakes now or already did earlier
    assign w_aw_ok = !r_awvalid || m_axi_awready;
    assign w_w_ok  = !r_wvalid || m_axi_wready;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: if (!w_empty) begin
                w_pop       = 1'b1;
                w_state_nxt = ST_XFER;
            end
            ST_XFER: if (w_aw_ok && w_w_ok) w_state_nxt = ST_RESP;
            ST_RESP: if (w_b_hs) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state   <= ST_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_done    <= 1'b0;
            r_resp    <= RESP_OKAY;
            r_err     <= 1'b0;
            r_ovf     <= 1'b0;
            r_stall   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            r_ovf   <= i_wr && w_full;

            // watchdog only flags; the FSM keeps waiting on the slave
            if (r_state != w_state_nxt) begin
                r_cnt <= '0;
            end else if (r_state != ST_IDLE && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) r_stall <= 1'b1;
            end

            case (r_state)
                ST_IDLE: if (!w_empty) begin
                    {r_awaddr, r_wdata, r_wstrb} <= w_head;
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                end
                ST_XFER: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_awaddr  <= '0;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_wdata  <= '0;
                        r_wstrb  <= '0;
                    end
                    if (w_aw_ok && w_w_ok) r_bready <= 1'b1;
                end
                ST_RESP: if (w_b_hs) begin
                    r_bready <= 1'b0;
                    r_resp   <= m_axi_bresp;
                    r_done   <= 1'b1;
                    if (m_axi_bresp != RESP_OKAY) r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_full        = w_full;
    assign o_busy        = !w_empty || (r_state != ST_IDLE);
    assign o_done        = r_done;
    assign o_resp        = r_resp;
    assign o_err         = r_err;
    assign o_ovf         = r_ovf;
    assign o_stall       = r_stall;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_bready  = r_bready;

endmodule
